// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one external combinational adder among NUM_REQ requesters.
// Optional signed-overflow flag output Ovf when ADDER_ARB_OVERFLOW_EN is defined.
module adder_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*WIDTH-1:0] OpA,
  input  logic [NUM_REQ*WIDTH-1:0] OpB,
  output logic [NUM_REQ-1:0]       Gnt,
  output logic [NUM_REQ-1:0]       Done,
  output logic [WIDTH-1:0]         Result,
  output logic                     Busy,
  output logic [WIDTH-1:0]         AddA,
  output logic [WIDTH-1:0]         AddB,
  input  logic [WIDTH-1:0]         AddS
`ifdef ADDER_ARB_OVERFLOW_EN
  ,
  output logic                     Ovf
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IDX_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] NUM_REQ_I = IDX_W'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;
`ifdef ADDER_ARB_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0]   op_a_arr [NUM_REQ];
  logic [WIDTH-1:0]   op_b_arr [NUM_REQ];
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [IDX_W-1:0]   scan_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_a_arr[gi] = OpA[gi*WIDTH +: WIDTH];
      assign op_b_arr[gi] = OpB[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the farthest candidate back to ptr so the closest requester wins last.
  always_comb begin
    found    = 1'b0;
    win      = ptr_q;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_q} + IDX_W'(k);
      if (scan_idx >= NUM_REQ_I) begin
        scan_idx = scan_idx - NUM_REQ_I;
      end
      if (Req[scan_idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    result_d = result_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
`ifdef ADDER_ARB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = EXEC;
          win_d   = win;
          gnt_d   = NUM_REQ'(1) << win;
          add_a_d = op_a_arr[win];
          add_b_d = op_b_arr[win];
        end
      end
      EXEC: begin
        result_d = AddS;
`ifdef ADDER_ARB_OVERFLOW_EN
        ovf_d    = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                   (AddS[WIDTH-1] != add_a_q[WIDTH-1]);
`endif
        state_d  = DONE;
      end
      DONE: begin
        ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + PTR_W'(1);
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      result_q <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
`ifdef ADDER_ARB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
`ifdef ADDER_ARB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign Gnt    = gnt_q;
  assign Done   = (state_q == DONE) ? gnt_q : '0;
  assign Busy   = (state_q != IDLE);
  assign Result = result_q;
  assign AddA   = add_a_q;
  assign AddB   = add_b_q;
`ifdef ADDER_ARB_OVERFLOW_EN
  assign Ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: transaction-level reference model plus directed scenarios.
// Build with ADDER_ARB_OVERFLOW_EN defined to also check the Ovf flag.
module tb_adder_share_arbiter;

  localparam int W    = 8;
  localparam int NREQ = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [NREQ-1:0]   Req = '0;
  logic [NREQ*W-1:0] OpA = '0;
  logic [NREQ*W-1:0] OpB = '0;
  logic [NREQ-1:0]   Gnt;
  logic [NREQ-1:0]   Done;
  logic [W-1:0]      Result;
  logic              Busy;
  logic [W-1:0]      AddA;
  logic [W-1:0]      AddB;
  logic [W-1:0]      AddS;
`ifdef ADDER_ARB_OVERFLOW_EN
  logic              Ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  adder_share_arbiter #(.WIDTH(W), .NUM_REQ(NREQ)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Req    (Req),
    .OpA    (OpA),
    .OpB    (OpB),
    .Gnt    (Gnt),
    .Done   (Done),
    .Result (Result),
    .Busy   (Busy),
    .AddA   (AddA),
    .AddB   (AddB),
    .AddS   (AddS)
`ifdef ADDER_ARB_OVERFLOW_EN
    ,
    .Ovf    (Ovf)
`endif
  );

  // The shared combinational full adder.
  assign AddS = AddA + AddB;

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] slice8(logic [NREQ*W-1:0] v, int i);
    return v[i*W +: W];
  endfunction

  function automatic logic [W-1:0] add_mod(logic [W-1:0] a, logic [W-1:0] b);
    int s;
    s = int'(a) + int'(b);
    return W'(s % 256);
  endfunction

`ifdef ADDER_ARB_OVERFLOW_EN
  function automatic logic signed_ovf(logic [W-1:0] a, logic [W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return (s > 127) || (s < -128);
  endfunction
`endif

  // m_age: -1 = no transaction, 0 = first cycle after grant, 1 = completion cycle.
  int         m_age = -1;
  int         m_ptr = 0;
  int         m_own = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
`ifdef ADDER_ARB_OVERFLOW_EN
  logic       m_ovf = 1'b0;
`endif

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_age <= -1;
      m_ptr <= 0;
      m_own <= 0;
      m_a   <= '0;
      m_b   <= '0;
      m_res <= '0;
`ifdef ADDER_ARB_OVERFLOW_EN
      m_ovf <= 1'b0;
`endif
    end else if (m_age == -1) begin
      if (rr_pick(Req, m_ptr) >= 0) begin
        m_age <= 0;
        m_own <= rr_pick(Req, m_ptr);
        m_a   <= slice8(OpA, rr_pick(Req, m_ptr));
        m_b   <= slice8(OpB, rr_pick(Req, m_ptr));
      end
    end else if (m_age == 0) begin
      m_age <= 1;
      m_res <= add_mod(m_a, m_b);
`ifdef ADDER_ARB_OVERFLOW_EN
      m_ovf <= signed_ovf(m_a, m_b);
`endif
    end else begin
      m_age <= -1;
      m_ptr <= (m_own + 1) % NREQ;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("cyc_gnt",  32'(Gnt),  (m_age >= 0) ? (32'd1 << m_own) : 32'd0);
      chk("cyc_done", 32'(Done), (m_age == 1) ? (32'd1 << m_own) : 32'd0);
      chk("cyc_busy", 32'(Busy), (m_age >= 0) ? 32'd1 : 32'd0);
      chk("cyc_adda", 32'(AddA), 32'(m_a));
      chk("cyc_addb", 32'(AddB), 32'(m_b));
      chk("cyc_result", 32'(Result), 32'(m_res));
`ifdef ADDER_ARB_OVERFLOW_EN
      chk("cyc_ovf", 32'(Ovf), 32'(m_ovf));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_sum, input logic exp_ovf, input string tag);
    OpA[i*W +: W] = a;
    OpB[i*W +: W] = b;
    Req[i] = 1'b1;
    @(negedge Clk);
    chk({tag, "_gnt"}, 32'(Gnt), 32'd1 << i);
    @(negedge Clk);
    chk({tag, "_done"}, 32'(Done), 32'd1 << i);
    chk({tag, "_result"}, 32'(Result), 32'(exp_sum));
`ifdef ADDER_ARB_OVERFLOW_EN
    chk({tag, "_ovf"}, 32'(Ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: unknown overflow expectation for %s", tag);
`endif
    Req[i] = 1'b0;
    @(negedge Clk);
    chk({tag, "_busy_low"}, 32'(Busy), 32'd0);
    $display("txn %s: req%0d %02h+%02h -> %02h", tag, i, a, b, Result);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] sums3 [NREQ];
    sums3[0] = 8'h11; sums3[1] = 8'h22; sums3[2] = 8'h33; sums3[3] = 8'h44;

    repeat (2) @(negedge Clk);
    cmp_en = 1'b1;
    chk("rst_gnt",    32'(Gnt),    32'd0);
    chk("rst_done",   32'(Done),   32'd0);
    chk("rst_busy",   32'(Busy),   32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    chk("rst_adda",   32'(AddA),   32'd0);
    chk("rst_addb",   32'(AddB),   32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // basic add and wraparound / overflow
    single(0, 8'h12, 8'h34, 8'h46, 1'b0, "t1");
    single(0, 8'hFF, 8'h02, 8'h01, 1'b0, "t2_wrap");
    single(0, 8'h7F, 8'h01, 8'h80, 1'b1, "t2_ovf");

    // grant to 1 moves ptr to 2; Req=0011 must then serve 0 before 1
    single(1, 8'h05, 8'h06, 8'h0B, 1'b0, "t4_pre");
    OpA[0*W +: W] = 8'h01; OpB[0*W +: W] = 8'h02;
    OpA[1*W +: W] = 8'h04; OpB[1*W +: W] = 8'h05;
    Req = 4'b0011;
    @(negedge Clk);
    @(negedge Clk);
    chk("t4_first_done", 32'(Done), 32'h1);
    chk("t4_first_result", 32'(Result), 32'h03);
    $display("txn t4: first done=%b result=%02h", Done, Result);
    Req[0] = 1'b0;
    repeat (2) @(negedge Clk);
    @(negedge Clk);
    chk("t4_second_done", 32'(Done), 32'h2);
    chk("t4_second_result", 32'(Result), 32'h09);
    $display("txn t4: second done=%b result=%02h", Done, Result);
    Req[1] = 1'b0;
    @(negedge Clk);

    // all four requesting from ptr=0: order 0,1,2,3, one done every 3 cycles
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      OpA[i*W +: W] = W'((i + 1) * 16);
      OpB[i*W +: W] = W'(i + 1);
    end
    Req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      @(negedge Clk);
      @(negedge Clk);
      chk("t3_done", 32'(Done), 32'd1 << k);
      chk("t3_result", 32'(Result), 32'(sums3[k]));
      $display("txn t3: done=%b result=%02h", Done, Result);
      Req[k] = 1'b0;
      @(negedge Clk);
    end

    // reset in the middle of an operation aborts it
    apply_reset();
    OpA[2*W +: W] = 8'h55;
    OpB[2*W +: W] = 8'h22;
    Req = 4'b0100;
    @(negedge Clk);
    chk("t5_gnt_exec", 32'(Gnt), 32'h4);
    #2 Reset = 1'b1;
    @(negedge Clk);
    chk("t5_rst_gnt",    32'(Gnt),    32'd0);
    chk("t5_rst_done",   32'(Done),   32'd0);
    chk("t5_rst_busy",   32'(Busy),   32'd0);
    chk("t5_rst_result", 32'(Result), 32'd0);
    chk("t5_rst_adda",   32'(AddA),   32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("t5_done", 32'(Done), 32'h4);
    chk("t5_result", 32'(Result), 32'h77);
    $display("txn t5: regrant done=%b result=%02h", Done, Result);
    Req = '0;
    @(negedge Clk);

    // operand change after grant is ignored
    OpA[1*W +: W] = 8'h10;
    OpB[1*W +: W] = 8'h01;
    Req = 4'b0010;
    @(negedge Clk);
    OpA[1*W +: W] = 8'h20;
    @(negedge Clk);
    chk("t6_done", 32'(Done), 32'h2);
    chk("t6_result", 32'(Result), 32'h11);
    $display("txn t6: done=%b result=%02h", Done, Result);
    Req = '0;
    repeat (3) @(negedge Clk);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
